cp0_unit: RTL and testbench
===========================

CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 Parameter HANDLER_ADDR, default 32'h0000_4180, exception entry address driven on handler_pc.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rd_sel  input  5  CP0 register number for the mfc0 read port.
REQ-005 wr_sel  input  5  CP0 register number for an mtc0 write.
REQ-006 we  input  1  mtc0 write enable.
REQ-007 wd  input  32  mtc0 write data.
REQ-008 vpc  input  32  PC of the instruction at the commit point (victim PC).
REQ-009 bd_in  input  1  victim instruction sits in a branch delay slot.
REQ-010 exc_code_in  input  5  synchronous exception code of the victim; 0 = none.
REQ-011 hw_int  input  6  level interrupt lines: bit0 = Timer0 IRQ, bit1 = Timer1 IRQ, bit2 = external interrupt, bits5:3 reserved.
REQ-012 eret  input  1  eret at commit point.
REQ-013 req  output  1  take exception/interrupt this cycle (flush pipeline, redirect PC).
REQ-014 handler_pc  output  32  constant HANDLER_ADDR.
REQ-015 epc_out  output  32  current EPC register value.
REQ-016 rd  output  32  mfc0 read data.

Function
REQ-017 Registers: SR(12) = IM[15:10], EXL[1], IE[0]; Cause(13) = BD[31], IP[15:10], ExcCode[6:2]; EPC(14) = 32 bits. All other bits read 0.
REQ-018 rd is combinational from rd_sel: 12/13/14 return the register image; any other number returns 0.
REQ-019 Cause.IP loads hw_int on every non-reset edge, independent of all other inputs.
REQ-020 int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL, using live hw_int, not Cause.IP.
REQ-021 exc_req = (exc_code_in != 0) & ~SR.EXL.
REQ-022 req = int_req | exc_req, combinational, same cycle.
REQ-023 Priority: an interrupt outranks a synchronous exception; when both are pending, ExcCode = 0.
REQ-024 On req, next edge: EXL <= 1; BD <= bd_in; ExcCode <= int_req ? 0 : exc_code_in; EPC <= bd_in ? vpc-4 : vpc, with bits[1:0] forced 0; IM and IE unchanged.
REQ-025 mtc0 to SR writes only IM, EXL and IE from the corresponding wd bits; other bits are ignored.
REQ-026 mtc0 to EPC writes wd[31:2] with bits[1:0] forced 0; mtc0 to Cause or to any other number has no effect.
REQ-027 If req and we are high in the same cycle, the write is discarded and req updates win.
REQ-028 eret with req low clears EXL on the next edge; if eret and we both target SR in the same cycle, eret wins for EXL only.
REQ-029 No EPC bypass: epc_out reflects the register, and the pipeline interlocks mtc0 EPC before eret.
REQ-030 While EXL = 1, no further req is raised, so nested exceptions are lost by design.

Reset
REQ-031 On reset, SR, Cause and EPC go to 0, so req = 0, rd = 0 and epc_out = 0 on the cycle after reset.
REQ-032 Reset overrides req, we and eret in the same cycle.

Structure
REQ-033 A shared package holds register numbers (12/13/14), bit-field positions, HANDLER_ADDR and ExcCode constants: Int = 0, AdEL = 4, AdES = 5, RI = 10, Ov = 12.
REQ-034 The block is a single module; the request/priority logic may be one sub-module, cp0_req_arb, and is otherwise flat.

Verification
REQ-035 Reset, then SR := 0x0000_0401, hw_int = 6'b000001 -> req = 1 same cycle; next edge EXL = 1, ExcCode = 0, EPC = vpc.
REQ-036 exc_code_in = 10, bd_in = 1, vpc = 0x3010 -> req = 1; EPC = 0x300C, Cause.BD = 1, ExcCode = 10.
REQ-037 EXL = 1 with hw_int asserted and exc_code_in = 12 -> req stays 0; eret -> EXL = 0 and req reasserts if the interrupt is still unmasked.
REQ-038 we to SR (wd = 0) in the same cycle as a pending interrupt -> write discarded; SR.IE still 1, EXL = 1.
REQ-039 mtc0 EPC wd = 0x0000_3007 -> epc_out = 0x0000_3004; mtc0 to Cause -> Cause unchanged; mfc0 of register 15 -> 0.
REQ-040 Assert reset mid-handler with EXL = 1 and EPC nonzero -> all registers return to 0 and req = 0.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes
// and packed register layouts used by the CP0 unit and its request arbiter.
package cp0_pkg;

    localparam logic [31:0] DEFAULT_HANDLER_ADDR = 32'h0000_4180;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;

    localparam int SR_IE_BIT    = 0;
    localparam int SR_EXL_BIT   = 1;
    localparam int SR_IM_LO     = 10;
    localparam int SR_IM_HI     = 15;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD_BIT = 31;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    typedef struct packed {
        logic       bd;
        logic [5:0] ip;
        logic [4:0] exc_code;
    } cause_t;

    function automatic logic [31:0] sr_image(input sr_t s);
        logic [31:0] img;
        img = '0;
        img[SR_IM_HI:SR_IM_LO] = s.im;
        img[SR_EXL_BIT]        = s.exl;
        img[SR_IE_BIT]         = s.ie;
        return img;
    endfunction

    function automatic logic [31:0] cause_image(input cause_t c);
        logic [31:0] img;
        img = '0;
        img[CAUSE_BD_BIT]                = c.bd;
        img[CAUSE_IP_HI:CAUSE_IP_LO]     = c.ip;
        img[CAUSE_EXC_HI:CAUSE_EXC_LO]   = c.exc_code;
        return img;
    endfunction

    // EPC always holds a word address.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/cp0_req_arb.sv
// Exception/interrupt request arbitration: decides whether to trap this cycle
// and which ExcCode to record. Interrupts outrank synchronous exceptions.
module cp0_req_arb
    import cp0_pkg::*;
(
    input  logic [5:0] hw_int,
    input  logic [5:0] im,
    input  logic       ie,
    input  logic       exl,
    input  logic [4:0] exc_code_in,
    output logic       req,
    output logic [4:0] exc_code
);

    logic int_req;
    logic exc_req;

    // Live interrupt lines are used, not the registered Cause.IP copy.
    always_comb begin
        int_req  = (|(hw_int & im)) & ie & ~exl;
        exc_req  = (exc_code_in != 5'd0) & ~exl;
        req      = int_req | exc_req;
        exc_code = int_req ? EXC_INT : exc_code_in;
    end

endmodule

// File: rtl/cp0_unit.sv
// Minimal CP0: Status, Cause and EPC registers, mfc0/mtc0 access, exception
// entry and eret return.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = DEFAULT_HANDLER_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rd_sel,
    input  logic [4:0]  wr_sel,
    input  logic        we,
    input  logic [31:0] wd,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        req,
    output logic [31:0] handler_pc,
    output logic [31:0] epc_out,
    output logic [31:0] rd
);

    sr_t         sr_q;
    cause_t      cause_q;
    logic [31:0] epc_q;
    logic [4:0]  sel_code;
    logic        sr_wr;
    logic        epc_wr;
    logic [31:0] trap_pc;

    cp0_req_arb u_arb (
        .hw_int      (hw_int),
        .im          (sr_q.im),
        .ie          (sr_q.ie),
        .exl         (sr_q.exl),
        .exc_code_in (exc_code_in),
        .req         (req),
        .exc_code    (sel_code)
    );

    always_comb begin
        sr_wr   = we && (wr_sel == CP0_SR);
        epc_wr  = we && (wr_sel == CP0_EPC);
        // A trapped delay-slot instruction restarts at its branch.
        trap_pc = bd_in ? (vpc - 32'd4) : vpc;
    end

    // A trap discards any same-cycle mtc0; eret is applied last so it wins EXL.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q    <= '0;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            cause_q.ip <= hw_int;
            if (req) begin
                sr_q.exl         <= 1'b1;
                cause_q.bd       <= bd_in;
                cause_q.exc_code <= sel_code;
                epc_q            <= word_align(trap_pc);
            end else begin
                if (sr_wr) begin
                    sr_q.im  <= wd[SR_IM_HI:SR_IM_LO];
                    sr_q.exl <= wd[SR_EXL_BIT];
                    sr_q.ie  <= wd[SR_IE_BIT];
                end
                if (epc_wr) begin
                    epc_q <= word_align(wd);
                end
                if (eret) begin
                    sr_q.exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd = '0;
        case (rd_sel)
            CP0_SR:    rd = sr_image(sr_q);
            CP0_CAUSE: rd = cause_image(cause_q);
            CP0_EPC:   rd = epc_q;
            default:   rd = '0;
        endcase
    end

    assign handler_pc = HANDLER_ADDR;
    assign epc_out    = epc_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: table of per-cycle stimulus with expected req, mfc0 data
// and EPC, plus hand-written reset sequences.
module tb_cp0_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  rd_sel;
    logic [4:0]  wr_sel;
    logic        we;
    logic [31:0] wd;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] handler_pc;
    logic [31:0] epc_out;
    logic [31:0] rd;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        we;
        logic [4:0]  wr_sel;
        logic [31:0] wd;
        logic [5:0]  hw;
        logic [4:0]  exc;
        logic        bd;
        logic [31:0] vpc;
        logic        eret;
        logic [4:0]  rd_sel;
        logic        exp_req;
        logic [31:0] exp_rd;
        logic [31:0] exp_epc;
    } vec_t;

    vec_t vecs[$];

    cp0_unit dut (
        .clk         (clk),
        .reset       (reset),
        .rd_sel      (rd_sel),
        .wr_sel      (wr_sel),
        .we          (we),
        .wd          (wd),
        .vpc         (vpc),
        .bd_in       (bd_in),
        .exc_code_in (exc_code_in),
        .hw_int      (hw_int),
        .eret        (eret),
        .req         (req),
        .handler_pc  (handler_pc),
        .epc_out     (epc_out),
        .rd          (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic we_i, input logic [4:0] ws, input logic [31:0] wdat,
                                input logic [5:0] hw, input logic [4:0] exc, input logic bd,
                                input logic [31:0] pc, input logic er, input logic [4:0] rs,
                                input logic er_req, input logic [31:0] er_rd, input logic [31:0] er_epc);
        vec_t v;
        v.we = we_i; v.wr_sel = ws; v.wd = wdat; v.hw = hw; v.exc = exc; v.bd = bd;
        v.vpc = pc; v.eret = er; v.rd_sel = rs;
        v.exp_req = er_req; v.exp_rd = er_rd; v.exp_epc = er_epc;
        return v;
    endfunction

    task automatic idle_inputs();
        we = 1'b0; wr_sel = 5'd0; wd = '0; vpc = '0; bd_in = 1'b0;
        exc_code_in = 5'd0; hw_int = 6'd0; eret = 1'b0; rd_sel = 5'd0;
    endtask

    task automatic drive_vec(input vec_t v);
        we = v.we; wr_sel = v.wr_sel; wd = v.wd; hw_int = v.hw; exc_code_in = v.exc;
        bd_in = v.bd; vpc = v.vpc; eret = v.eret; rd_sel = v.rd_sel;
    endtask

    task automatic check(input string name, input logic [31:0] act);
        logic [31:0] exp;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: act=%h exp=<queue empty>", name, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                bad++;
                $display("FAIL %s: act=%h exp=%h", name, act, exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // stimulus table: we, wr_sel, wd, hw, exc, bd, vpc, eret, rd_sel, req, rd, epc
        vecs.push_back(mk(1, 12, 32'h0000_0401, 6'd0, 0,  0, 32'h0,    0, 12, 0, 32'h0000_0401, 32'h0));
        vecs.push_back(mk(0, 0,  32'h0,         6'd1, 0,  0, 32'h1000, 0, 13, 1, 32'h0000_0400, 32'h1000));
        vecs.push_back(mk(0, 0,  32'h0,         6'd1, 0,  0, 32'h0,    0, 12, 0, 32'h0000_0403, 32'h1000));
        vecs.push_back(mk(0, 0,  32'h0,         6'd1, 12, 0, 32'h2000, 0, 13, 0, 32'h0000_0400, 32'h1000));
        vecs.push_back(mk(0, 0,  32'h0,         6'd1, 0,  0, 32'h0,    1, 12, 0, 32'h0000_0401, 32'h1000));
        vecs.push_back(mk(0, 0,  32'h0,         6'd1, 0,  0, 32'h2004, 0, 14, 1, 32'h0000_2004, 32'h2004));
        vecs.push_back(mk(0, 0,  32'h0,         6'd0, 0,  0, 32'h0,    1, 12, 0, 32'h0000_0401, 32'h2004));
        vecs.push_back(mk(0, 0,  32'h0,         6'd0, 10, 1, 32'h3010, 0, 13, 1, 32'h8000_0028, 32'h300C));
        vecs.push_back(mk(0, 0,  32'h0,         6'd0, 0,  0, 32'h0,    1, 14, 0, 32'h0000_300C, 32'h300C));
        vecs.push_back(mk(1, 12, 32'h0,         6'd1, 0,  0, 32'h4000, 0, 12, 1, 32'h0000_0403, 32'h4000));
        vecs.push_back(mk(1, 12, 32'h0000_0403, 6'd0, 0,  0, 32'h0,    1, 12, 0, 32'h0000_0401, 32'h4000));
        vecs.push_back(mk(1, 12, 32'hFFFF_FFFF, 6'd0, 0,  0, 32'h0,    0, 12, 0, 32'h0000_FC03, 32'h4000));
        vecs.push_back(mk(1, 12, 32'h0000_0801, 6'd0, 0,  0, 32'h0,    0, 12, 0, 32'h0000_0801, 32'h4000));
        vecs.push_back(mk(0, 0,  32'h0,         6'd1, 0,  0, 32'h0,    0, 13, 0, 32'h0000_0400, 32'h4000));
        vecs.push_back(mk(0, 0,  32'h0,         6'd2, 4,  0, 32'h5008, 0, 13, 1, 32'h0000_0800, 32'h5008));
        vecs.push_back(mk(1, 14, 32'h0000_3007, 6'd2, 0,  0, 32'h0,    0, 14, 0, 32'h0000_3004, 32'h3004));
        vecs.push_back(mk(1, 13, 32'hFFFF_FFFF, 6'd2, 0,  0, 32'h0,    0, 13, 0, 32'h0000_0800, 32'h3004));
        vecs.push_back(mk(1, 15, 32'hFFFF_FFFF, 6'd0, 0,  0, 32'h0,    0, 15, 0, 32'h0000_0000, 32'h3004));
        vecs.push_back(mk(0, 0,  32'h0,         6'd0, 5,  0, 32'h0,    0, 13, 0, 32'h0000_0000, 32'h3004));
        vecs.push_back(mk(0, 0,  32'h0,         6'd0, 0,  0, 32'h0,    1, 12, 0, 32'h0000_0801, 32'h3004));
        vecs.push_back(mk(0, 0,  32'h0,         6'd0, 12, 0, 32'h6003, 0, 14, 1, 32'h0000_6000, 32'h6000));

        // clock/reset
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        exp_q.push_back(32'h0);
        check("reset_req", {31'd0, req});
        exp_q.push_back(32'h0);
        check("reset_epc_out", epc_out);
        exp_q.push_back(32'h0000_4180);
        check("handler_pc", handler_pc);
        for (int r = 12; r <= 14; r++) begin
            rd_sel = 5'(r);
            #1;
            exp_q.push_back(32'h0);
            check($sformatf("reset_rd%0d", r), rd);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            drive_vec(vecs[i]);
            exp_q.push_back({31'd0, vecs[i].exp_req});
            exp_q.push_back(vecs[i].exp_rd);
            exp_q.push_back(vecs[i].exp_epc);
            @(negedge clk);
            check($sformatf("v%0d_req", i), {31'd0, req});
            step();
            check($sformatf("v%0d_rd", i), rd);
            check($sformatf("v%0d_epc", i), epc_out);
        end

        // Reset mid-handler (EXL=1, EPC nonzero) with write, eret and a pending trap.
        we = 1'b1; wr_sel = 5'd12; wd = 32'h0000_0403; eret = 1'b1;
        exc_code_in = 5'd10; hw_int = 6'd1; vpc = 32'h7000; bd_in = 1'b1;
        reset = 1'b1;
        step();
        // Second reset cycle: now EXL=0, so a trap would fire without reset.
        wr_sel = 5'd14; wd = 32'h0000_1234; eret = 1'b0;
        step();
        reset = 1'b0;
        idle_inputs();
        hw_int = 6'd1;
        #1;
        exp_q.push_back(32'h0);
        check("post_reset_req", {31'd0, req});
        exp_q.push_back(32'h0);
        check("post_reset_epc_out", epc_out);
        for (int r = 12; r <= 14; r++) begin
            rd_sel = 5'(r);
            #1;
            exp_q.push_back(32'h0);
            check($sformatf("post_reset_rd%0d", r), rd);
        end

        // First clean edge: Cause.IP follows the line, but SR is zero so no request.
        rd_sel = 5'd13;
        step();
        exp_q.push_back(32'h0000_0400);
        check("ip_after_reset", rd);
        exp_q.push_back(32'h0);
        check("masked_req", {31'd0, req});

        if (exp_q.size() != 0) begin
            bad++;
            total++;
            $display("FAIL scoreboard_leftover: act=%0d exp=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
